// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase encoding, lamp vector,
// and the state-to-lamp decode used by the FSM's registered outputs.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_B  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    EMERG     = 3'd7
  } state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
  } lamps_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // Exactly one lamp per road; any state not granting a road shows red there.
  function automatic lamps_t state_lamps(input state_t s);
    lamps_t l;
    l.ns = LAMP_RED;
    l.ew = LAMP_RED;
    case (s)
      NS_GREEN:  l.ns = LAMP_GREEN;
      NS_YELLOW: l.ns = LAMP_YELLOW;
      EW_GREEN:  l.ew = LAMP_GREEN;
      EW_YELLOW: l.ew = LAMP_YELLOW;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads DURATION-1 on phase entry, counts down on ticks,
// and parks at zero so the FSM can see expiry on the next tick.
module phase_timer import traffic_pkg::*; #(
  parameter int             CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise decrement on tick until zero is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_o  = cnt;
  assign zero_o = (cnt == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with pedestrian walk phase and emergency
// all-red override. Phase time is measured in external tick pulses.
module traffic_intersection_ctrl import traffic_pkg::*; #(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             emerg,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             ped_walk,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] timer_o
);

  localparam longint MAX_TICKS = longint'(1) << CNT_W;

  if (GREEN_TICKS < 1 || longint'(GREEN_TICKS) > MAX_TICKS) begin : g_bad_green
    $error("GREEN_TICKS out of range 1..2**CNT_W");
  end
  if (YELLOW_TICKS < 1 || longint'(YELLOW_TICKS) > MAX_TICKS) begin : g_bad_yellow
    $error("YELLOW_TICKS out of range 1..2**CNT_W");
  end
  if (ALLRED_TICKS < 1 || longint'(ALLRED_TICKS) > MAX_TICKS) begin : g_bad_allred
    $error("ALLRED_TICKS out of range 1..2**CNT_W");
  end
  if (PED_TICKS < 1 || longint'(PED_TICKS) > MAX_TICKS) begin : g_bad_ped
    $error("PED_TICKS out of range 1..2**CNT_W");
  end

  // Reload values are DURATION-1 so a phase spans exactly DURATION ticks.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_TICKS - 1);

  state_t           state;
  state_t           nxt_state;
  logic             ped_pending;
  lamps_t           lamps;
  logic             walk;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             enter_walk;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt_o    (timer_o),
    .zero_o   (tmr_zero)
  );

  // Next-phase decision: emergency beats expiry, expiry beats pedestrian request.
  always_comb begin
    nxt_state = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (tick) begin
      case (state)
        NS_GREEN: begin
          if (emerg || tmr_zero) begin
            nxt_state = NS_YELLOW;
            tmr_load  = 1'b1;
            tmr_val   = YELLOW_LD;
          end
        end
        NS_YELLOW: begin
          if (tmr_zero) begin
            nxt_state = ALLRED_A;
            tmr_load  = 1'b1;
            tmr_val   = ALLRED_LD;
          end
        end
        ALLRED_A: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (emerg) begin
              nxt_state = EMERG;
              tmr_val   = '0;
            end else begin
              nxt_state = EW_GREEN;
              tmr_val   = GREEN_LD;
            end
          end
        end
        EW_GREEN: begin
          if (emerg || tmr_zero) begin
            nxt_state = EW_YELLOW;
            tmr_load  = 1'b1;
            tmr_val   = YELLOW_LD;
          end
        end
        EW_YELLOW: begin
          if (tmr_zero) begin
            nxt_state = ALLRED_B;
            tmr_load  = 1'b1;
            tmr_val   = ALLRED_LD;
          end
        end
        ALLRED_B: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (emerg) begin
              nxt_state = EMERG;
              tmr_val   = '0;
            end else if (ped_pending) begin
              nxt_state = PED_WALK;
              tmr_val   = PED_LD;
            end else begin
              nxt_state = NS_GREEN;
              tmr_val   = GREEN_LD;
            end
          end
        end
        PED_WALK: begin
          if (emerg) begin
            nxt_state = EMERG;
            tmr_load  = 1'b1;
            tmr_val   = '0;
          end else if (tmr_zero) begin
            nxt_state = NS_GREEN;
            tmr_load  = 1'b1;
            tmr_val   = GREEN_LD;
          end
        end
        EMERG: begin
          if (!emerg) begin
            nxt_state = ALLRED_B;
            tmr_load  = 1'b1;
            tmr_val   = ALLRED_LD;
          end
        end
        default: begin
          nxt_state = ALLRED_B;
          tmr_load  = 1'b1;
          tmr_val   = ALLRED_LD;
        end
      endcase
    end
  end

  // The request is consumed on the edge that starts the walk phase.
  assign enter_walk = (state == ALLRED_B) && (nxt_state == PED_WALK);

  // Phase register, pending pedestrian flag and lamp outputs registered from the next phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALLRED_B;
      ped_pending <= 1'b0;
      lamps       <= state_lamps(ALLRED_B);
      walk        <= 1'b0;
    end else begin
      state <= nxt_state;
      lamps <= state_lamps(nxt_state);
      walk  <= (nxt_state == PED_WALK);
      if (enter_walk) begin
        ped_pending <= 1'b0;
      end else if (ped_req && (state != PED_WALK)) begin
        ped_pending <= 1'b1;
      end
    end
  end

  assign ns_red    = lamps.ns.red;
  assign ns_yellow = lamps.ns.yellow;
  assign ns_green  = lamps.ns.green;
  assign ew_red    = lamps.ew.red;
  assign ew_yellow = lamps.ew.yellow;
  assign ew_green  = lamps.ew.green;
  assign ped_walk  = walk;
  assign state_o   = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with default parameters.
module tb_traffic_intersection_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b1;
  logic             ped_req = 1'b0;
  logic             emerg = 1'b0;
  logic             ns_red, ns_yellow, ns_green;
  logic             ew_red, ew_yellow, ew_green;
  logic             ped_walk;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] timer_o;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl #(
    .CNT_W        (CNT_W),
    .GREEN_TICKS  (8),
    .YELLOW_TICKS (3),
    .ALLRED_TICKS (2),
    .PED_TICKS    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .ped_req   (ped_req),
    .emerg     (emerg),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .ped_walk  (ped_walk),
    .state_o   (state_o),
    .timer_o   (timer_o)
  );

  always #5 clk = ~clk;

  wire [6:0] lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ns r,y,g, ew r,y,g, walk} for each phase encoding
  function automatic logic [6:0] exp_lamps(input logic [2:0] s);
    case (s)
      3'd1:    return 7'b001_100_0;
      3'd2:    return 7'b010_100_0;
      3'd4:    return 7'b100_001_0;
      3'd5:    return 7'b100_010_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_st(input string tag, input int st, input int tm);
    logic [2:0] s3;
    s3 = st[2:0];
    chk({tag, ".state"}, 32'(state_o), st);
    chk({tag, ".timer"}, 32'(timer_o), tm);
    chk({tag, ".lamps"}, 32'(lamps), 32'(exp_lamps(s3)));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    tick    = 1'b1;
    ped_req = 1'b0;
    emerg   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("reset", 0, 1);
    rst = 1'b0;
  endtask

  int seq_st[6] = '{0, 1, 2, 3, 4, 5};
  int seq_d[6]  = '{2, 8, 3, 2, 8, 3};

  initial begin
    // Normal sequence, tick every cycle, two full periods
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < 6; p++) begin
        for (int k = seq_d[p] - 1; k >= 0; k--) begin
          chk_st("seq", seq_st[p], k);
          chk("seq.one_red", 32'(ns_red | ew_red), 1);
          step();
        end
      end
    end
    chk_st("seq.wrap", 0, 1);

    // Tick every 4th cycle; state and timer hold between ticks
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int k = seq_d[p] - 1; k >= 0; k--) begin
        chk_st("slow", seq_st[p], k);
        tick = 1'b0;
        repeat (3) begin
          step();
          chk_st("slow.hold", seq_st[p], k);
        end
        tick = 1'b1;
        step();
      end
    end
    chk_st("slow.wrap", 0, 1);

    // Pedestrian request during EW_GREEN
    do_reset();
    run(15);
    chk_st("ped.ewg", 4, 7);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run(7);
    chk_st("ped.ewy", 5, 2);
    run(3);
    chk_st("ped.arb", 0, 1);
    run(2);
    chk_st("ped.walk", 6, 4);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk_st("ped.walk3", 6, 3);
    run(4);
    chk_st("ped.nsg", 1, 7);
    run(26);
    chk_st("ped.no_rewalk", 1, 7);

    // Emergency at the 3rd tick of NS_GREEN
    do_reset();
    run(2);
    chk_st("em.nsg", 1, 7);
    run(2);
    chk_st("em.nsg5", 1, 5);
    emerg = 1'b1;
    step();
    chk_st("em.nsy", 2, 2);
    run(3);
    chk_st("em.ara", 3, 1);
    run(2);
    chk_st("em.emerg", 7, 0);
    run(5);
    chk_st("em.hold", 7, 0);
    emerg = 1'b0;
    step();
    chk_st("em.exit", 0, 1);
    run(2);
    chk_st("em.nsg_again", 1, 7);

    // Emergency during PED_WALK, request latched in EMERG served afterwards
    do_reset();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk_st("pe.arb0", 0, 0);
    step();
    chk_st("pe.walk", 6, 4);
    step();
    emerg = 1'b1;
    step();
    chk_st("pe.emerg", 7, 0);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run(3);
    chk_st("pe.hold", 7, 0);
    emerg = 1'b0;
    step();
    chk_st("pe.exit", 0, 1);
    run(2);
    chk_st("pe.walk2", 6, 4);
    run(5);
    chk_st("pe.nsg", 1, 7);

    // Asynchronous reset in EW_GREEN with timer 4 discards a pending request
    do_reset();
    run(15);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run(2);
    chk_st("ar.ewg4", 4, 4);
    #2;
    rst = 1'b1;
    #1;
    chk_st("ar.async", 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(2);
    chk_st("ar.no_ped", 1, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
